// File: rtl/demux_dispatch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch_queue_if
// Description : Request/issue bundle for demux_dispatch_queue.
//               slave modport  : the dispatch queue itself.
//               master modport : whatever feeds requests and watches issues.
//   in_valid/in_ready/in_sel/in_y : request handshake and payload
//   ch_busy                       : per-channel busy flags (bit i blocks ch i)
//   out_valid/s/y/a               : registered issue strobe, select, bit,
//                                   one-hot gated output
//   count                         : FIFO occupancy
//   stall_cnt                     : blocked-cycle counter, only when
//                                   DISPATCH_STALL_CNT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_dispatch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_sel;
  logic          in_y;
  logic [7:0]    ch_busy;
  logic          out_valid;
  logic [2:0]    s;
  logic          y;
  logic [7:0]    a;
  logic [CW-1:0] count;
`ifdef DISPATCH_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  modport slave (
    input  in_valid, in_sel, in_y, ch_busy,
    output in_ready, out_valid, s, y, a, count
`ifdef DISPATCH_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport master (
    output in_valid, in_sel, in_y, ch_busy,
    input  in_ready, out_valid, s, y, a, count
`ifdef DISPATCH_STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/demux_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch_queue
// Description : In-order buffered issue stage in front of a 1-to-8 demux.
//               Requests {sel, y} are queued in a DEPTH-entry FIFO and the
//               head is issued only when its channel is not busy. An issue
//               produces a one-cycle out_valid with registered s, y and
//               a = (1 << s) & {8{y}}.
// Ports       : clk   - rising-edge clock
//               clrn  - asynchronous active-low reset
//               bus   - demux_dispatch_queue_if.slave (request handshake,
//                       ch_busy, issue outputs, count, optional stall_cnt)
// Options     : DISPATCH_STALL_CNT_EN adds a saturating 16-bit counter of
//               cycles in which a non-empty FIFO had its head blocked.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dispatch_queue #(
  parameter int DEPTH = 4
) (
  input  wire                     clk,
  input  wire                     clrn,
  demux_dispatch_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Each entry packs {sel[2:0], y}.
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_next_state;
  logic [2:0]    r_s;
  logic          r_y;
  logic [7:0]    r_a;

  logic [3:0]    w_head;
  logic [2:0]    w_head_sel;
  logic          w_head_y;
  logic          w_empty;
  logic          w_head_blocked;
  logic          w_push;
  logic          w_pop;
  logic          w_in_ready;

  assign w_head         = r_mem[r_rd_ptr];
  assign w_head_sel     = w_head[3:1];
  assign w_head_y       = w_head[0];
  assign w_empty        = (r_count == '0);
  assign w_head_blocked = bus.ch_busy[w_head_sel];

  // Acceptance is decoded from the registered occupancy only; a pop on the
  // same edge does not open a slot early. Held low while in reset.
  assign w_in_ready = clrn & (r_count < C_DEPTH);
  assign w_push     = bus.in_valid & w_in_ready;
  // A request pushed at this edge is not yet visible to the head, so an
  // empty FIFO can never issue on the edge that fills it.
  assign w_pop      = ~w_empty & ~w_head_blocked;

  // Storage carries no reset: stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_sel, bus.in_y};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue state: SEND is the cycle following a pop. Every state decides its
  // successor from the head currently presented, which after a SEND is the
  // entry behind the one just issued.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_SEND: begin
        if (w_empty)             w_next_state = ST_IDLE;
        else if (w_head_blocked) w_next_state = ST_WAIT;
        else                     w_next_state = ST_SEND;
      end
      ST_WAIT: begin
        if (w_empty)             w_next_state = ST_IDLE;
        else if (w_head_blocked) w_next_state = ST_WAIT;
        else                     w_next_state = ST_SEND;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Issue registers: s/y keep the last issued request between issues,
  // while a returns to zero whenever nothing is issued.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_s <= 3'd0;
      r_y <= 1'b0;
      r_a <= 8'h00;
    end else if (w_pop) begin
      r_s <= w_head_sel;
      r_y <= w_head_y;
      r_a <= (8'h01 << w_head_sel) & {8{w_head_y}};
    end else begin
      r_a <= 8'h00;
    end
  end

`ifdef DISPATCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Counts every edge at which a queued head was held back, whether the
  // queue was already waiting or had just become blocked.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stall_cnt <= 16'h0000;
    end else if (!w_empty && w_head_blocked && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_SEND);
  assign bus.s         = r_s;
  assign bus.y         = r_y;
  assign bus.a         = r_a;
  assign bus.count     = r_count;

endmodule
`default_nettype wire
